// File: rtl/ls_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : ls_wb_stage
// Function : LSU output stage; 2-entry skid buffer feeding the LS->WB register,
//            with flush and a retired-beat counter.
// Revision : 1.0
// ============================================================================
module ls_wb_stage #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ls_in_valid,
    output logic             ls_in_ready,
    input  logic [375:0]     ls_in_bundle,
    input  logic             WB_LS_ls_ready,
    input  logic             WB_LS_flush_flag,
    output logic             LS_WB_reg_ls_valid,
    output logic [63:0]      LS_WB_reg_PC,
    output logic [63:0]      LS_WB_reg_next_PC,
    output logic [31:0]      LS_WB_reg_inst,
    output logic             LS_WB_reg_trap_valid,
    output logic             LS_WB_reg_mret_valid,
    output logic             LS_WB_reg_sret_valid,
    output logic             LS_WB_reg_dret_valid,
    output logic [63:0]      LS_WB_reg_trap_cause,
    output logic [63:0]      LS_WB_reg_trap_tval,
    output logic             LS_WB_reg_csr_wen,
    output logic             LS_WB_reg_csr_ren,
    output logic [11:0]      LS_WB_reg_csr_addr,
    output logic [4:0]       LS_WB_reg_rd,
    output logic             LS_WB_reg_dest_wen,
    output logic [63:0]      LS_WB_reg_data,
    output logic [CNT_W-1:0] retire_cnt
);

    // State bits are {main_valid, skid_valid}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [375:0]       r_main;
    logic [375:0]       r_skid;
    logic [CNT_W-1:0]   r_retire_cnt;
    logic               w_in_hs;
    logic               w_out_hs;
    logic               w_main_load_in;
    logic               w_main_load_skid;
    logic               w_skid_load;

    assign ls_in_ready = ~r_state[0];
    assign w_in_hs     = ls_in_valid & ls_in_ready;
    assign w_out_hs    = r_state[1] & WB_LS_ls_ready;

    always_comb begin
        w_state_next     = r_state;
        w_main_load_in   = 1'b0;
        w_main_load_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_hs) begin
                    w_state_next   = ONE;
                    w_main_load_in = 1'b1;
                end
            end
            ONE: begin
                if (w_in_hs && w_out_hs) begin
                    w_main_load_in = 1'b1;
                end else if (w_in_hs) begin
                    w_state_next = FULL;
                    w_skid_load  = 1'b1;
                end else if (w_out_hs) begin
                    w_state_next = EMPTY;
                end
            end
            FULL: begin
                if (w_out_hs) begin
                    w_state_next     = ONE;
                    w_main_load_skid = 1'b1;
                end
            end
            default: w_state_next = EMPTY;
        endcase
        // Flush wins over everything; payload left stale since valid bits clear
        if (WB_LS_flush_flag) begin
            w_state_next     = EMPTY;
            w_main_load_in   = 1'b0;
            w_main_load_skid = 1'b0;
            w_skid_load      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_main       <= '0;
            r_skid       <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_main_load_in)
                r_main <= ls_in_bundle;
            else if (w_main_load_skid)
                r_main <= r_skid;
            if (w_skid_load)
                r_skid <= ls_in_bundle;
            if (w_out_hs)
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign LS_WB_reg_ls_valid   = r_state[1];
    assign LS_WB_reg_PC         = r_main[375:312];
    assign LS_WB_reg_next_PC    = r_main[311:248];
    assign LS_WB_reg_inst       = r_main[247:216];
    assign LS_WB_reg_trap_valid = r_main[215];
    assign LS_WB_reg_mret_valid = r_main[214];
    assign LS_WB_reg_sret_valid = r_main[213];
    assign LS_WB_reg_dret_valid = r_main[212];
    assign LS_WB_reg_trap_cause = r_main[211:148];
    assign LS_WB_reg_trap_tval  = r_main[147:84];
    assign LS_WB_reg_csr_wen    = r_main[83];
    assign LS_WB_reg_csr_ren    = r_main[82];
    assign LS_WB_reg_csr_addr   = r_main[81:70];
    assign LS_WB_reg_rd         = r_main[69:65];
    assign LS_WB_reg_dest_wen   = r_main[64];
    assign LS_WB_reg_data       = r_main[63:0];
    assign retire_cnt           = r_retire_cnt;

endmodule
`default_nettype wire

// File: doc/ls_wb_stage.md
# ls_wb_stage

Output stage of the LSU that drives the LS→WB pipeline register consumed by the write-back unit. It accepts one completed instruction per cycle from LSU internals over a valid/ready handshake and holds it in a 2-entry skid buffer. It presents the bundle on the `LS_WB_reg_*` ports, honours `WB_LS_ls_ready` back-pressure, and drops all buffered work on `WB_LS_flush_flag`. It also keeps a retired-beat counter for performance monitoring.

## Interface
- `CNT_W`, default 64: width of the retire counter.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ls_in_valid`  in  1  upstream beat valid.
- `ls_in_ready`  out  1  stage can accept a beat; registered, equals NOT skid_valid.
- `ls_in_bundle`  in  376  packed beat, MSB→LSB:
  - PC[375:312], next_PC[311:248], inst[247:216]
  - trap_valid[215], mret[214], sret[213], dret[212]
  - trap_cause[211:148], trap_tval[147:84]
  - csr_wen[83], csr_ren[82], csr_addr[81:70]
  - rd[69:65], dest_wen[64], data[63:0]
- `WB_LS_ls_ready`  in  1  WBU accepts the presented beat.
- `WB_LS_flush_flag`  in  1  WBU redirect; discard everything buffered.
- `LS_WB_reg_ls_valid`  out  1  presented beat valid.
- `LS_WB_reg_PC`, `LS_WB_reg_next_PC`  out  64 each  PC fields.
- `LS_WB_reg_inst`  out  32  instruction word.
- `LS_WB_reg_trap_valid`, `LS_WB_reg_mret_valid`, `LS_WB_reg_sret_valid`, `LS_WB_reg_dret_valid`  out  1 each  trap/return flags.
- `LS_WB_reg_trap_cause`, `LS_WB_reg_trap_tval`  out  64 each  trap info.
- `LS_WB_reg_csr_wen`, `LS_WB_reg_csr_ren`  out  1 each  CSR access flags.
- `LS_WB_reg_csr_addr`  out  12  CSR address.
- `LS_WB_reg_rd`  out  5  destination register.
- `LS_WB_reg_dest_wen`  out  1  GPR write enable.
- `LS_WB_reg_data`  out  64  result data.
- `retire_cnt`  out  CNT_W  count of accepted downstream beats.

## Operation
- Storage: main entry (drives all `LS_WB_reg_*` outputs) plus skid entry, each a 376-bit payload with a valid bit. `LS_WB_reg_ls_valid` = main_valid.
- Handshakes:
  - in_hs = `ls_in_valid` & `ls_in_ready`.
  - out_hs = main_valid & `WB_LS_ls_ready`.
- States, encoded by {main_valid, skid_valid}:
  - EMPTY:
    - in_hs → ONE, main ← in.
  - ONE:
    - in_hs & out_hs → ONE, main ← in.
    - in_hs & !out_hs → FULL, skid ← in.
    - !in_hs & out_hs → EMPTY.
    - otherwise hold.
  - FULL:
    - `ls_in_ready`=0.
    - out_hs → ONE, main ← skid.
    - otherwise hold.
- Order: beats leave in arrival order, with no duplication and no loss except by flush.
- Flush: `WB_LS_flush_flag`=1 forces next state EMPTY, overriding all transitions. A beat offered on the flush cycle is discarded even if in_hs=1.
- Retire counter: `retire_cnt` += 1 on every out_hs, including an out_hs in a flush cycle. It wraps modulo 2^CNT_W silently.
- Payload is opaque; no field is inspected or modified. Invalid entries keep their stale payload, since only valid bits gate behaviour.

## Timing
- Reset (async, immediate):
  - main_valid=0, skid_valid=0, `ls_in_ready`=1, `retire_cnt`=0.
  - All payload outputs = 0.
- Latency: a beat accepted at edge N drives `LS_WB_reg_*` from edge N (registered outputs), i.e. visible the cycle after the in_hs cycle.
- Throughput: 1 beat/cycle with `WB_LS_ls_ready` held 1; the skid entry is never used in that case.
- Back-pressure: `ls_in_ready` drops the cycle after entering FULL. It rises the cycle after the first out_hs from FULL.
- Upstream rule: `ls_in_valid`/`ls_in_bundle` must hold until in_hs. Downstream gets the same guarantee: the presented beat is stable until out_hs or flush.
- Flush + out_hs in the same cycle: the beat counts as retired, and both entries are cleared at the edge.
- Reset asserted mid-operation clears entries and counter at once. The first acceptance is possible on the first edge after release.

## Test plan
- Reset:
  - Stimulus: assert `rst` with random inputs.
  - Response: `LS_WB_reg_ls_valid`=0, `ls_in_ready`=1, `retire_cnt`=0, all payload outputs 0.
- Streaming:
  - Stimulus: `WB_LS_ls_ready`=1; push beats with PC 0x80000000, 0x80000004, … back-to-back.
  - Response: each appears one cycle later in order; `retire_cnt`=N after N beats; `ls_in_ready` stays 1.
- Back-pressure:
  - Stimulus: `WB_LS_ls_ready`=0; push PC A, B, C.
  - Response: A presented; B held in skid; `ls_in_ready`=0 so C is not taken. Release ready: outputs A, B, C in order, and `retire_cnt` +3.
- Flush while FULL:
  - Stimulus: hold A (main) and B (skid); pulse `WB_LS_flush_flag` with `WB_LS_ls_ready`=1 and `ls_in_valid`=1 carrying C.
  - Response: `retire_cnt` +1 (A); next cycle EMPTY; B and C never presented; `ls_in_ready`=1.
- Field integrity:
  - Stimulus: push a bundle with trap_valid=1, trap_cause=0x8000000000000007, csr_addr=0x300, rd=5, data=0xDEADBEEF.
  - Response: every `LS_WB_reg_*` field matches bit-exact.
- Counter wrap and reset mid-run:
  - Stimulus: CNT_W=4, 17 retires.
  - Response: `retire_cnt`=1.
  - Stimulus: assert `rst` while FULL.
  - Response: immediate EMPTY, `retire_cnt`=0.
